// File: rtl/diff_pkg.sv
// ============================================================================
// Module  : diff_pkg
// Brief   : Shared types and helpers for the diff_counter button front end.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package diff_pkg;

  localparam int CNT_W = 5;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    CONFIRM_HI = 2'd1,
    HELD       = 2'd2,
    CONFIRM_LO = 2'd3
  } deb_state_e;

  // The display decoder takes the raw two's-complement bits as {sinal, diff}.
  function automatic logic [CNT_W-1:0] to_sm(input logic signed [CNT_W-1:0] count);
    return count;
  endfunction

endpackage

`default_nettype wire

// File: rtl/button_debounce.sv
// ============================================================================
// Module  : button_debounce
// Brief   : 2-flop synchroniser plus debounce FSM; one pulse per accepted press.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module button_debounce
  import diff_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic press_pulse
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q, sync2_q;
  deb_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          pulse_q, pulse_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      state_q <= IDLE;
      cnt_q   <= '0;
      pulse_q <= 1'b0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pulse_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (sync2_q) begin
          state_d = CONFIRM_HI;
          cnt_d   = CW'(1);
        end
      end
      CONFIRM_HI: begin
        if (!sync2_q) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q >= CNT_LAST) begin
          state_d = HELD;
          cnt_d   = '0;
          pulse_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      HELD: begin
        if (!sync2_q) begin
          state_d = CONFIRM_LO;
          cnt_d   = CW'(1);
        end
      end
      CONFIRM_LO: begin
        if (sync2_q) begin
          state_d = HELD;
          cnt_d   = '0;
        end else if (cnt_q >= CNT_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign press_pulse = pulse_q;

endmodule

`default_nettype wire

// File: rtl/diff_counter.sv
// ============================================================================
// Module  : diff_counter
// Brief   : Saturating signed up/down count driven by two debounced buttons.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module diff_counter
  import diff_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int LIMIT           = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       clear,
  output logic [3:0] diff,
  output logic       sinal,
  output logic       at_max,
  output logic       at_min
);

  localparam logic signed [CNT_W-1:0] LIM_POS = CNT_W'(LIMIT);
  localparam logic signed [CNT_W-1:0] LIM_NEG = -LIM_POS;

  logic                    up_pulse, down_pulse;
  logic signed [CNT_W-1:0] count_q, count_d;
  logic                    at_max_q, at_min_q;

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_up (
    .clk         (clk),
    .rst_n       (rst_n),
    .raw         (btn_up),
    .press_pulse (up_pulse)
  );

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_down (
    .clk         (clk),
    .rst_n       (rst_n),
    .raw         (btn_down),
    .press_pulse (down_pulse)
  );

  // Clear wins over pulses; opposing pulses cancel; limits hold silently.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (up_pulse && down_pulse) begin
      count_d = count_q;
    end else if (up_pulse) begin
      if (count_q < LIM_POS) count_d = count_q + 5'sd1;
    end else if (down_pulse) begin
      if (count_q > LIM_NEG) count_d = count_q - 5'sd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q  <= '0;
      at_max_q <= 1'b0;
      at_min_q <= 1'b0;
    end else begin
      count_q  <= count_d;
      at_max_q <= (count_d == LIM_POS);
      at_min_q <= (count_d == LIM_NEG);
    end
  end

  assign {sinal, diff} = to_sm(count_q);
  assign at_max        = at_max_q;
  assign at_min        = at_min_q;

endmodule

`default_nettype wire
